alu_trap_ctrl: RTL and testbench

//  Consumer of the ALU flag outputs (zero/of/uof) at the execute/retire boundary.
//  - Samples the flags for every accepted ADD/SUB.
//  - Turns enabled overflow conditions into a held exception request with cause and EPC.
//  - Stalls the pipe until the handler acknowledges, then issues a one-cycle flush.
//  - Keeps saturating overflow event counters for debug/perf readout.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/sat_counter.sv | 19 +
 rtl/alu_trap_ctrl.sv | 113 +++++++++++
 tb/tb_alu_trap_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU flag consumer: op codes, trap causes and
// the trap controller state encoding.
package alu_pkg;

  localparam logic [3:0] ALUOP_ADD = 4'd5;
  localparam logic [3:0] ALUOP_SUB = 4'd6;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_SOV  = 2'b01;
  localparam logic [1:0] CAUSE_UOV  = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FLUSH = 2'd2
  } trap_state_t;

  // Overflow flags only carry meaning for add/subtract.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == ALUOP_ADD) || (op == ALUOP_SUB);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_trap_ctrl.sv
// Execute/retire-boundary consumer of ALU flags: counts overflow events and
// turns enabled overflows into a held exception request followed by a flush.
//
// Handshake: a bundle on in_valid is taken only in a cycle where stall is low
// (no ready path back from the bundle); exc_req is held high until exc_ack is
// sampled high, after which flush pulses for exactly one cycle.
module alu_trap_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [3:0]            in_aluop,
  input  logic                  in_zero,
  input  logic                  in_of,
  input  logic                  in_uof,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [1:0]            trap_en,
  output logic                  stall,
  output logic                  exc_req,
  input  logic                  exc_ack,
  output logic [1:0]            exc_cause,
  output logic [DATA_WIDTH-1:0] exc_epc,
  output logic                  flush,
  output logic                  zero_q,
  output logic [CNT_WIDTH-1:0]  of_cnt,
  output logic [CNT_WIDTH-1:0]  uof_cnt,
  output logic [1:0]            dbg_state
);

  trap_state_t state_q, state_d;

  logic       accept;
  logic       of_qual, uof_qual;
  logic [1:0] trap_cause;
  logic       trap;

  assign accept     = in_valid && (state_q == ST_IDLE);
  assign of_qual    = in_of  && is_arith(in_aluop);
  assign uof_qual   = in_uof && is_arith(in_aluop);
  assign trap_cause = {uof_qual & trap_en[1], of_qual & trap_en[0]};
  assign trap       = |trap_cause;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode the registered state only, so no input reaches them combinationally.
  always_comb begin
    state_d = state_q;
    exc_req = 1'b0;
    flush   = 1'b0;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && trap) state_d = ST_REQ;
      end
      ST_REQ: begin
        exc_req = 1'b1;
        stall   = 1'b1;
        if (exc_ack) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush   = 1'b1;
        stall   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_cause <= CAUSE_NONE;
      exc_epc   <= '0;
      zero_q    <= 1'b0;
    end else begin
      if (accept) zero_q <= in_zero;
      if (accept && trap) begin
        exc_cause <= trap_cause;
        exc_epc   <= in_pc;
      end else if (state_q == ST_FLUSH) begin
        exc_cause <= CAUSE_NONE;
      end
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_of_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept && of_qual),
    .count (of_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_uof_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept && uof_qual),
    .count (uof_cnt)
  );

  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_trap_ctrl.sv
// Directed bench for alu_trap_ctrl: a behavioural model of the trap rules is
// compared against every output each cycle, plus hand-computed spot values.
module tb_alu_trap_ctrl;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [3:0]    in_aluop;
  logic          in_zero, in_of, in_uof;
  logic [DW-1:0] in_pc;
  logic [1:0]    trap_en;
  logic          stall, exc_req, exc_ack, flush, zero_q;
  logic [1:0]    exc_cause;
  logic [DW-1:0] exc_epc;
  logic [CW-1:0] of_cnt, uof_cnt;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;

  // Model: a trap is "pending" until acknowledged, then a flush is "due" for one cycle.
  bit            m_pending, m_flush_due, m_zero;
  logic [1:0]    m_cause;
  logic [DW-1:0] m_epc;
  int            m_of, m_uof;

  always #5 clk = ~clk;

  alu_trap_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_aluop(in_aluop),
    .in_zero(in_zero), .in_of(in_of), .in_uof(in_uof), .in_pc(in_pc),
    .trap_en(trap_en), .stall(stall), .exc_req(exc_req), .exc_ack(exc_ack),
    .exc_cause(exc_cause), .exc_epc(exc_epc), .flush(flush), .zero_q(zero_q),
    .of_cnt(of_cnt), .uof_cnt(uof_cnt), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next model values from the inputs present just before the edge.
  task automatic model_edge();
    bit busy, of_e, uof_e;
    if (rst) begin
      m_pending = 0; m_flush_due = 0; m_zero = 0;
      m_cause = 2'b00; m_epc = '0; m_of = 0; m_uof = 0;
      return;
    end
    busy = m_pending || m_flush_due;
    if (m_flush_due) begin
      m_flush_due = 0;
      m_cause = 2'b00;
    end else if (m_pending) begin
      if (exc_ack) begin
        m_pending = 0;
        m_flush_due = 1;
      end
    end
    if (!busy && in_valid) begin
      of_e  = in_of  && (in_aluop == 4'd5 || in_aluop == 4'd6);
      uof_e = in_uof && (in_aluop == 4'd5 || in_aluop == 4'd6);
      m_zero = in_zero;
      if (of_e  && m_of  < CNT_MAX) m_of++;
      if (uof_e && m_uof < CNT_MAX) m_uof++;
      if ((of_e && trap_en[0]) || (uof_e && trap_en[1])) begin
        m_pending = 1;
        m_cause = {uof_e && trap_en[1], of_e && trap_en[0]};
        m_epc = in_pc;
      end
    end
  endtask

  task automatic compare_cycle();
    check("stall",     stall,     m_pending || m_flush_due);
    check("exc_req",   exc_req,   m_pending);
    check("flush",     flush,     m_flush_due);
    check("exc_cause", exc_cause, m_cause);
    check("exc_epc",   exc_epc,   m_epc);
    check("zero_q",    zero_q,    m_zero);
    check("of_cnt",    of_cnt,    m_of[CW-1:0]);
    check("uof_cnt",   uof_cnt,   m_uof[CW-1:0]);
  endtask

  // One clock: advance the model, take the edge, compare on the falling edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(posedge clk);
      @(negedge clk);
      compare_cycle();
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic z,
                       input logic o, input logic u, input logic [DW-1:0] pc,
                       input logic [1:0] en);
    in_valid = v; in_aluop = op; in_zero = z; in_of = o; in_uof = u;
    in_pc = pc; trap_en = en;
  endtask

  task automatic idle_in();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, '0, 2'b00);
  endtask

  initial begin
    rst = 1'b1; exc_ack = 1'b0;
    idle_in();
    @(negedge clk);
    step(2);
    check("reset_stall", stall, 1'b0);
    check("reset_cnt",   of_cnt, 16'h0);
    rst = 1'b0;
    step(1);

    // 1: SUB signed overflow with signed trap enabled.
    drive(1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 32'h400, 2'b01);
    step(1);
    check("t1_req",   exc_req, 1'b1);
    check("t1_cause", exc_cause, 2'b01);
    check("t1_epc",   exc_epc, 32'h400);
    check("t1_stall", stall, 1'b1);
    idle_in();
    step(2);
    exc_ack = 1'b1;
    step(1);
    check("t1_flush", flush, 1'b1);
    check("t1_req_drop", exc_req, 1'b0);
    step(1); // ack still high must not skip or repeat the flush
    check("t1_flush_end", flush, 1'b0);
    check("t1_stall_end", stall, 1'b0);
    check("t1_cause_clr", exc_cause, 2'b00);
    exc_ack = 1'b0;

    // 2: unsigned overflow without enable, accepted in the first free cycle.
    drive(1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 32'h404, 2'b00);
    step(1);
    check("t2_req",  exc_req, 1'b0);
    check("t2_uof",  uof_cnt, 16'd1);
    check("t2_zero", zero_q, 1'b1);

    // 3: both overflows, both enabled; bundles during REQ are dropped.
    drive(1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 32'h800, 2'b11);
    step(1);
    check("t3_cause", exc_cause, 2'b11);
    drive(1'b1, 4'd6, 1'b1, 1'b1, 1'b1, 32'h900, 2'b11);
    step(3);
    check("t3_of_hold",  of_cnt, 16'd2);
    check("t3_uof_hold", uof_cnt, 16'd2);
    check("t3_epc_hold", exc_epc, 32'h800);
    check("t3_zero_hold", zero_q, 1'b0);
    idle_in();
    exc_ack = 1'b1;
    step(1);
    exc_ack = 1'b0;
    step(2);

    // 4: non-arithmetic op never traps or counts but still updates zero_q.
    drive(1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 32'hA00, 2'b11);
    step(1);
    check("t4_req",  exc_req, 1'b0);
    check("t4_of",   of_cnt, 16'd2);
    check("t4_zero", zero_q, 1'b1);
    idle_in();
    exc_ack = 1'b1; // ack in IDLE is ignored
    step(2);
    exc_ack = 1'b0;

    // 6: reset while in REQ with ack high.
    drive(1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 32'hC00, 2'b01);
    step(1);
    check("t6_req", exc_req, 1'b1);
    idle_in();
    exc_ack = 1'b1;
    rst = 1'b1;
    step(1);
    check("t6_req",   exc_req, 1'b0);
    check("t6_flush", flush, 1'b0);
    check("t6_epc",   exc_epc, 32'h0);
    check("t6_cnt",   of_cnt, 16'h0);
    check("t6_state", dbg_state, 2'd0);
    rst = 1'b0;
    exc_ack = 1'b0;
    step(1);
    check("t6_no_flush", flush, 1'b0);

    // 5: drive the signed counter to all-ones, then once more.
    drive(1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 32'hF00, 2'b00);
    step(CNT_MAX);
    check("t5_full", of_cnt, 16'hFFFF);
    step(1);
    check("t5_sat", of_cnt, 16'hFFFF);
    check("t5_uof", uof_cnt, 16'h0);
    idle_in();
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
